// File: rtl/bus_frame_pkg.sv
// bus_frame_pkg: shared constants and FSM state type for bus_frame_packer.
// BUS_FRAME_CRC_EN adds the TRAILER state carrying the payload XOR.
package bus_frame_pkg;

    localparam int unsigned WORD_W      = 64;
    localparam int unsigned DROP_W      = 16;
    localparam logic [15:0] FRAME_MAGIC = 16'hA5C3;

    typedef enum logic [1:0] {
        IDLE,
        HEADER,
        PAYLOAD
`ifdef BUS_FRAME_CRC_EN
        ,
        TRAILER
`endif
    } frame_state_t;

    // Header layout: magic | sequence | drop snapshot | payload length.
    function automatic logic [WORD_W-1:0] make_header(
        input logic [15:0]       seq,
        input logic [DROP_W-1:0] drops,
        input logic [15:0]       len
    );
        return {FRAME_MAGIC, seq, drops, len};
    endfunction

endpackage

// File: rtl/bus_word_fifo.sv
// bus_word_fifo: synchronous FIFO, power-of-two depth, head word readable
// combinationally. Push when full and pop when empty are ignored.
module bus_word_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 64
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned AW       = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // Next pointer and occupancy values.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage array; contents need no reset because occupancy gates reads.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/bus_frame_packer.sv
// bus_frame_packer: buffers 64-bit sample words and emits framed output
// (header + FRAME_WORDS payload words) on a valid/ready stream. Words that
// arrive while the FIFO is full are dropped and counted (saturating).
// Optional feature macro: BUS_FRAME_CRC_EN appends an XOR trailer word.
import bus_frame_pkg::*;

module bus_frame_packer #(
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned FRAME_WORDS = 4
) (
    input  logic              clk_50mhz,
    input  logic              rst_n,
    input  logic [WORD_W-1:0] in_word,
    input  logic              in_valid,
    output logic [WORD_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_sof,
    output logic              out_eof,
    output logic [DROP_W-1:0] drop_cnt
);

    localparam int unsigned CW        = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] START_CNT = CW'(FRAME_WORDS);
    localparam logic [CW-1:0] LAST_BEAT = CW'(FRAME_WORDS - 1);
    localparam logic [15:0]   LEN_FIELD = 16'(FRAME_WORDS);

    logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [CW-1:0]     fifo_count;
    logic [WORD_W-1:0] fifo_head;

    frame_state_t      state_q, state_d;
    logic [15:0]       seq_q, seq_d;
    logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;
    logic [DROP_W-1:0] snap_q, snap_d;
    logic [CW-1:0]     beat_q, beat_d;
`ifdef BUS_FRAME_CRC_EN
    logic [WORD_W-1:0] xor_q, xor_d;
`endif

    // Fullness is the pre-edge value, so a same-cycle pop never rescues a word.
    assign fifo_push = in_valid && !fifo_full;
    assign drop_cnt  = drop_cnt_q;

    bus_word_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (WORD_W)
    ) u_fifo (
        .clk_i   (clk_50mhz),
        .rst_ni  (rst_n),
        .push_i  (fifo_push),
        .data_i  (in_word),
        .pop_i   (fifo_pop),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Saturating drop counter.
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (in_valid && fifo_full && (drop_cnt_q != '1)) begin
            drop_cnt_d = drop_cnt_q + DROP_W'(1);
        end
    end

    // Framing FSM: next state, bookkeeping and outputs. Outputs decode the
    // registered state, so they hold while stalled and clear with async reset.
    always_comb begin
        state_d   = state_q;
        seq_d     = seq_q;
        snap_d    = snap_q;
        beat_d    = beat_q;
`ifdef BUS_FRAME_CRC_EN
        xor_d     = xor_q;
`endif
        fifo_pop  = 1'b0;
        out_valid = 1'b0;
        out_sof   = 1'b0;
        out_eof   = 1'b0;
        out_data  = '0;
        case (state_q)
            IDLE: begin
                if (fifo_count >= START_CNT) begin
                    state_d = HEADER;
                    snap_d  = drop_cnt_q;
                    beat_d  = '0;
`ifdef BUS_FRAME_CRC_EN
                    xor_d   = '0;
`endif
                end
            end
            HEADER: begin
                out_valid = 1'b1;
                out_sof   = 1'b1;
                out_data  = make_header(seq_q, snap_q, LEN_FIELD);
                if (out_ready) begin
                    state_d = PAYLOAD;
                end
            end
            PAYLOAD: begin
                out_valid = 1'b1;
                out_data  = fifo_head;
`ifndef BUS_FRAME_CRC_EN
                out_eof   = (beat_q == LAST_BEAT);
`endif
                if (out_ready) begin
                    fifo_pop = !fifo_empty;
                    beat_d   = beat_q + CW'(1);
`ifdef BUS_FRAME_CRC_EN
                    xor_d    = xor_q ^ fifo_head;
`endif
                    if (beat_q == LAST_BEAT) begin
                        seq_d = seq_q + 16'd1;
`ifdef BUS_FRAME_CRC_EN
                        state_d = TRAILER;
`else
                        state_d = IDLE;
`endif
                    end
                end
            end
`ifdef BUS_FRAME_CRC_EN
            TRAILER: begin
                out_valid = 1'b1;
                out_eof   = 1'b1;
                out_data  = xor_q;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clk_50mhz or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            seq_q      <= '0;
            drop_cnt_q <= '0;
            snap_q     <= '0;
            beat_q     <= '0;
`ifdef BUS_FRAME_CRC_EN
            xor_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            seq_q      <= seq_d;
            drop_cnt_q <= drop_cnt_d;
            snap_q     <= snap_d;
            beat_q     <= beat_d;
`ifdef BUS_FRAME_CRC_EN
            xor_q      <= xor_d;
`endif
        end
    end

endmodule

// File: tb/tb_bus_frame_packer.sv
// tb_bus_frame_packer: directed self-checking bench for bus_frame_packer
// (DEPTH=8, FRAME_WORDS=4). Expectations follow BUS_FRAME_CRC_EN if defined.
module tb_bus_frame_packer;

    localparam int FW = 4;

    logic        clk_50mhz;
    logic        rst_n;
    logic [63:0] in_word;
    logic        in_valid;
    logic [63:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_sof;
    logic        out_eof;
    logic [15:0] drop_cnt;

    int errors = 0;
    int checks = 0;

    logic [63:0] exp_q[$];
    logic [63:0] d;
    logic        s, e;
    int          waits;
    bit          ok;

    bus_frame_packer #(
        .DEPTH       (8),
        .FRAME_WORDS (FW)
    ) dut (
        .clk_50mhz (clk_50mhz),
        .rst_n     (rst_n),
        .in_word   (in_word),
        .in_valid  (in_valid),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sof   (out_sof),
        .out_eof   (out_eof),
        .drop_cnt  (drop_cnt)
    );

    initial begin
        clk_50mhz = 1'b0;
        forever #10 clk_50mhz = ~clk_50mhz;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
        $fatal(1);
    end

    // Expected frame: header, FW consecutive words from base, optional XOR trailer.
    function automatic void build_frame(input logic [15:0] seq, input logic [15:0] drops,
                                        input logic [63:0] base);
        logic [63:0] x;
        logic [63:0] w;
        exp_q.delete();
        exp_q.push_back({16'hA5C3, seq, drops, 16'(FW)});
        x = '0;
        for (int k = 0; k < FW; k++) begin
            w = base + 64'(k);
            exp_q.push_back(w);
            x = x ^ w;
        end
`ifdef BUS_FRAME_CRC_EN
        exp_q.push_back(x);
`endif
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk_50mhz);
        rst_n = 1'b1;
        @(negedge clk_50mhz);
    endtask

    task automatic push_range(input logic [63:0] base, input int n);
        for (int k = 0; k < n; k++) begin
            in_word  = base + 64'(k);
            in_valid = 1'b1;
            @(negedge clk_50mhz);
        end
        in_valid = 1'b0;
    endtask

    // Waits (bounded) for out_valid with out_ready already high; returns the beat.
    task automatic get_beat(output logic [63:0] bd, output logic bs, output logic be,
                            output int bw, output bit bok);
        bd = 'x; bs = 'x; be = 'x; bw = 0; bok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid === 1'b1) begin
                bd = out_data; bs = out_sof; be = out_eof; bw = i; bok = 1'b1;
                @(negedge clk_50mhz);
                return;
            end
            @(negedge clk_50mhz);
        end
    endtask

    task automatic test_reset();
        in_valid = 1'b0; in_word = '0; out_ready = 1'b0; rst_n = 1'b0;
        repeat (2) @(negedge clk_50mhz);
        checks++;
        if (out_valid !== 1'b0 || out_sof !== 1'b0 || out_eof !== 1'b0 || out_data !== 64'h0) begin
            errors++;
            $display("FAIL reset_outputs: got valid=%b sof=%b eof=%b data=%h, want 0 0 0 0",
                     out_valid, out_sof, out_eof, out_data);
        end
        checks++;
        if (drop_cnt !== 16'h0) begin
            errors++;
            $display("FAIL reset_drop: got %h, want 0000", drop_cnt);
        end
        rst_n = 1'b1;
        @(negedge clk_50mhz);
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        push_range(64'h1, 4);
        build_frame(16'h0000, 16'h0000, 64'h1);
        for (int k = 0; k < exp_q.size(); k++) begin
            get_beat(d, s, e, waits, ok);
            checks++;
            if (!ok || d !== exp_q[k] || s !== (k == 0) || e !== (k == exp_q.size() - 1) ||
                (k > 0 && waits != 0)) begin
                errors++;
                $display("FAIL basic beat%0d: got data=%h sof=%b eof=%b seen=%b gap=%0d, want data=%h sof=%b eof=%b gap=0",
                         k, d, s, e, ok, waits, exp_q[k], k == 0, k == exp_q.size() - 1);
            end
        end
    endtask

    task automatic test_threshold();
        bit early;
        out_ready = 1'b1;
        push_range(64'h10, 3);
        early = 1'b0;
        for (int c = 0; c < 5; c++) begin
            if (out_valid !== 1'b0) early = 1'b1;
            @(negedge clk_50mhz);
        end
        checks++;
        if (early) begin
            errors++;
            $display("FAIL threshold_three_words: got out_valid=1 with 3 words, want 0");
        end
        push_range(64'h13, 1);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL threshold_latency_early: got out_valid=%b one edge after 4th push, want 0", out_valid);
        end
        @(negedge clk_50mhz);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 64'hA5C3_0001_0000_0004) begin
            errors++;
            $display("FAIL threshold_header_latency: got valid=%b data=%h, want 1 a5c3000100000004",
                     out_valid, out_data);
        end
        build_frame(16'h0001, 16'h0000, 64'h10);
        for (int k = 0; k < exp_q.size(); k++) begin
            get_beat(d, s, e, waits, ok);
            checks++;
            if (!ok || d !== exp_q[k] || s !== (k == 0) || e !== (k == exp_q.size() - 1) ||
                (k > 0 && waits != 0)) begin
                errors++;
                $display("FAIL threshold beat%0d: got data=%h sof=%b eof=%b seen=%b gap=%0d, want data=%h sof=%b eof=%b gap=0",
                         k, d, s, e, ok, waits, exp_q[k], k == 0, k == exp_q.size() - 1);
            end
        end
    endtask

    task automatic test_stall_toggle();
        int          idx;
        logic        prev_stall;
        logic [63:0] pd;
        logic        ps, pe;
        out_ready = 1'b0;
        push_range(64'hFACE_0000_0000_0100, 4);
        build_frame(16'h0002, 16'h0000, 64'hFACE_0000_0000_0100);
        idx = 0; prev_stall = 1'b0; pd = '0; ps = 1'b0; pe = 1'b0;
        for (int c = 0; c < 80 && idx < exp_q.size(); c++) begin
            if (prev_stall) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== pd || out_sof !== ps || out_eof !== pe) begin
                    errors++;
                    $display("FAIL stall_hold cyc%0d: got valid=%b data=%h sof=%b eof=%b, want 1 %h %b %b",
                             c, out_valid, out_data, out_sof, out_eof, pd, ps, pe);
                end
            end
            out_ready = c[0];
            if (out_valid === 1'b1 && out_ready) begin
                checks++;
                if (out_data !== exp_q[idx] || out_sof !== (idx == 0) || out_eof !== (idx == exp_q.size() - 1)) begin
                    errors++;
                    $display("FAIL stall_beat%0d: got data=%h sof=%b eof=%b, want %h %b %b",
                             idx, out_data, out_sof, out_eof, exp_q[idx], idx == 0, idx == exp_q.size() - 1);
                end
                idx++;
            end
            prev_stall = (out_valid === 1'b1) && !out_ready;
            pd = out_data; ps = out_sof; pe = out_eof;
            @(negedge clk_50mhz);
        end
        checks++;
        if (idx != exp_q.size()) begin
            errors++;
            $display("FAIL stall_count: got %0d beats accepted, want %0d", idx, exp_q.size());
        end
        out_ready = 1'b1;
    endtask

    task automatic test_drop();
        bit moved;
        do_reset();
        out_ready = 1'b0;
        push_range(64'h0000_0100_0000_0000, 10);
        checks++;
        if (drop_cnt !== 16'h0002) begin
            errors++;
            $display("FAIL drop_count: got %h, want 0002", drop_cnt);
        end
        moved = 1'b0;
        for (int c = 0; c < 3; c++) begin
            if (out_valid !== 1'b1 || out_sof !== 1'b1 || out_data !== 64'hA5C3_0000_0000_0004) moved = 1'b1;
            @(negedge clk_50mhz);
        end
        checks++;
        if (moved) begin
            errors++;
            $display("FAIL drop_stalled_header: got valid=%b sof=%b data=%h, want 1 1 a5c3000000000004",
                     out_valid, out_sof, out_data);
        end
        out_ready = 1'b1;
        build_frame(16'h0000, 16'h0000, 64'h0000_0100_0000_0000);
        for (int k = 0; k < exp_q.size(); k++) begin
            get_beat(d, s, e, waits, ok);
            checks++;
            if (!ok || d !== exp_q[k] || s !== (k == 0) || e !== (k == exp_q.size() - 1) ||
                (k > 0 && waits != 0)) begin
                errors++;
                $display("FAIL drop_f0 beat%0d: got data=%h sof=%b eof=%b seen=%b gap=%0d, want data=%h sof=%b eof=%b gap=0",
                         k, d, s, e, ok, waits, exp_q[k], k == 0, k == exp_q.size() - 1);
            end
        end
        build_frame(16'h0001, 16'h0002, 64'h0000_0100_0000_0004);
        for (int k = 0; k < exp_q.size(); k++) begin
            get_beat(d, s, e, waits, ok);
            checks++;
            if (!ok || d !== exp_q[k] || s !== (k == 0) || e !== (k == exp_q.size() - 1) ||
                waits != ((k == 0) ? 1 : 0)) begin
                errors++;
                $display("FAIL drop_f1 beat%0d: got data=%h sof=%b eof=%b seen=%b gap=%0d, want data=%h sof=%b eof=%b gap=%0d",
                         k, d, s, e, ok, waits, exp_q[k], k == 0, k == exp_q.size() - 1, (k == 0) ? 1 : 0);
            end
        end
    endtask

    task automatic test_drop_on_pop();
        do_reset();
        out_ready = 1'b0;
        push_range(64'h0000_0200_0000_0000, 8);
        checks++;
        if (drop_cnt !== 16'h0000) begin
            errors++;
            $display("FAIL pop_drop_pre: got %h, want 0000", drop_cnt);
        end
        out_ready = 1'b1;
        @(negedge clk_50mhz);
        build_frame(16'h0000, 16'h0000, 64'h0000_0200_0000_0000);
        checks++;
        if (out_valid !== 1'b1 || out_data !== exp_q[1]) begin
            errors++;
            $display("FAIL pop_drop_first_payload: got valid=%b data=%h, want 1 %h", out_valid, out_data, exp_q[1]);
        end
        in_word  = 64'hDEAD_DEAD_DEAD_DEAD;
        in_valid = 1'b1;
        @(negedge clk_50mhz);
        in_valid = 1'b0;
        checks++;
        if (drop_cnt !== 16'h0001) begin
            errors++;
            $display("FAIL pop_drop_same_edge: got %h, want 0001", drop_cnt);
        end
        for (int k = 2; k < exp_q.size(); k++) begin
            get_beat(d, s, e, waits, ok);
            checks++;
            if (!ok || d !== exp_q[k] || s !== 1'b0 || e !== (k == exp_q.size() - 1) || waits != 0) begin
                errors++;
                $display("FAIL pop_f0 beat%0d: got data=%h sof=%b eof=%b seen=%b gap=%0d, want data=%h sof=0 eof=%b gap=0",
                         k, d, s, e, ok, waits, exp_q[k], k == exp_q.size() - 1);
            end
        end
        build_frame(16'h0001, 16'h0001, 64'h0000_0200_0000_0004);
        for (int k = 0; k < exp_q.size(); k++) begin
            get_beat(d, s, e, waits, ok);
            checks++;
            if (!ok || d !== exp_q[k] || s !== (k == 0) || e !== (k == exp_q.size() - 1) ||
                (k > 0 && waits != 0)) begin
                errors++;
                $display("FAIL pop_f1 beat%0d: got data=%h sof=%b eof=%b seen=%b gap=%0d, want data=%h sof=%b eof=%b gap=0",
                         k, d, s, e, ok, waits, exp_q[k], k == 0, k == exp_q.size() - 1);
            end
        end
        repeat (3) @(negedge clk_50mhz);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL pop_drained: got out_valid=%b with fifo drained, want 0", out_valid);
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1;
        push_range(64'h0000_0300_0000_0000, 4);
        get_beat(d, s, e, waits, ok);
        get_beat(d, s, e, waits, ok);
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_sof !== 1'b0 || out_data !== 64'h0000_0300_0000_0001) begin
            errors++;
            $display("FAIL midreset_setup: got valid=%b sof=%b data=%h, want 1 0 0000030000000001",
                     out_valid, out_sof, out_data);
        end
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_sof !== 1'b0 || out_eof !== 1'b0 || out_data !== 64'h0 ||
            drop_cnt !== 16'h0) begin
            errors++;
            $display("FAIL midreset_async: got valid=%b sof=%b eof=%b data=%h drop=%h, want all zero",
                     out_valid, out_sof, out_eof, out_data, drop_cnt);
        end
        @(negedge clk_50mhz);
        rst_n = 1'b1;
        @(negedge clk_50mhz);
        out_ready = 1'b1;
        push_range(64'h0000_0400_0000_0000, 4);
        build_frame(16'h0000, 16'h0000, 64'h0000_0400_0000_0000);
        for (int k = 0; k < exp_q.size(); k++) begin
            get_beat(d, s, e, waits, ok);
            checks++;
            if (!ok || d !== exp_q[k] || s !== (k == 0) || e !== (k == exp_q.size() - 1) ||
                (k > 0 && waits != 0)) begin
                errors++;
                $display("FAIL midreset_next beat%0d: got data=%h sof=%b eof=%b seen=%b gap=%0d, want data=%h sof=%b eof=%b gap=0",
                         k, d, s, e, ok, waits, exp_q[k], k == 0, k == exp_q.size() - 1);
            end
        end
    endtask

    task automatic test_wrap();
        force dut.seq_q = 16'hFFFF;
        force dut.drop_cnt_q = 16'hFFFF;
        @(negedge clk_50mhz);
        release dut.seq_q;
        release dut.drop_cnt_q;
        @(negedge clk_50mhz);
        checks++;
        if (drop_cnt !== 16'hFFFF) begin
            errors++;
            $display("FAIL wrap_preload: got drop=%h, want ffff", drop_cnt);
        end
        out_ready = 1'b1;
        push_range(64'h0000_0500_0000_0000, 4);
        build_frame(16'hFFFF, 16'hFFFF, 64'h0000_0500_0000_0000);
        for (int k = 0; k < exp_q.size(); k++) begin
            get_beat(d, s, e, waits, ok);
            checks++;
            if (!ok || d !== exp_q[k] || s !== (k == 0) || e !== (k == exp_q.size() - 1) ||
                (k > 0 && waits != 0)) begin
                errors++;
                $display("FAIL wrap_ffff beat%0d: got data=%h sof=%b eof=%b seen=%b gap=%0d, want data=%h sof=%b eof=%b gap=0",
                         k, d, s, e, ok, waits, exp_q[k], k == 0, k == exp_q.size() - 1);
            end
        end
        out_ready = 1'b0;
        push_range(64'h0000_0600_0000_0000, 10);
        checks++;
        if (drop_cnt !== 16'hFFFF) begin
            errors++;
            $display("FAIL wrap_drop_saturate: got %h, want ffff", drop_cnt);
        end
        out_ready = 1'b1;
        build_frame(16'h0000, 16'hFFFF, 64'h0000_0600_0000_0000);
        for (int k = 0; k < exp_q.size(); k++) begin
            get_beat(d, s, e, waits, ok);
            checks++;
            if (!ok || d !== exp_q[k] || s !== (k == 0) || e !== (k == exp_q.size() - 1) ||
                (k > 0 && waits != 0)) begin
                errors++;
                $display("FAIL wrap_0000 beat%0d: got data=%h sof=%b eof=%b seen=%b gap=%0d, want data=%h sof=%b eof=%b gap=0",
                         k, d, s, e, ok, waits, exp_q[k], k == 0, k == exp_q.size() - 1);
            end
        end
        build_frame(16'h0001, 16'hFFFF, 64'h0000_0600_0000_0004);
        for (int k = 0; k < exp_q.size(); k++) begin
            get_beat(d, s, e, waits, ok);
            checks++;
            if (!ok || d !== exp_q[k] || s !== (k == 0) || e !== (k == exp_q.size() - 1) ||
                (k > 0 && waits != 0)) begin
                errors++;
                $display("FAIL wrap_0001 beat%0d: got data=%h sof=%b eof=%b seen=%b gap=%0d, want data=%h sof=%b eof=%b gap=0",
                         k, d, s, e, ok, waits, exp_q[k], k == 0, k == exp_q.size() - 1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_threshold();
        test_stall_toggle();
        test_drop();
        test_drop_on_pop();
        test_reset_mid();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
